sample_mgmt_mc: RTL

SAMPLE_MGMT_MC -- requirements
Module: sample_mgmt_mc

---
 rtl/sample_mgmt_pkg.sv | 14 +
 rtl/sample_ch_ctr.sv | 64 ++++++
 rtl/sample_mgmt_mc.sv | 82 ++++++++
 3 files changed

// File: rtl/sample_mgmt_pkg.sv
// Shared types and default sizing for the multi-channel sample manager.
package sample_mgmt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int DEF_N_CH      = 4;
  localparam int DEF_CTR_WIDTH = 24;
  localparam int DEF_SATURATE  = 1;

endpackage

// File: rtl/sample_ch_ctr.sv
// One sample channel: counter, sticky done (bounded records) and sticky overflow (unbounded).
module sample_ch_ctr
  import sample_mgmt_pkg::*;
#(
  parameter int CTR_WIDTH = DEF_CTR_WIDTH,
  parameter int SATURATE  = DEF_SATURATE
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_clr,
  input  logic                 i_inc,
  input  logic [CTR_WIDTH-1:0] i_len,
  output logic [CTR_WIDTH-1:0] o_ctr,
  output logic                 o_done,
  output logic                 o_done_nxt,
  output logic                 o_overflow
);

  logic [CTR_WIDTH-1:0] ctr_q, ctr_d, ctr_inc;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;

  assign ctr_inc = ctr_q + {{(CTR_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    ctr_d  = ctr_q;
    done_d = done_q;
    ovf_d  = ovf_q;
    if (i_clr) begin
      ctr_d  = '0;
      done_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (i_inc && !done_q) begin
      if (|i_len) begin
        ctr_d = ctr_inc;
        if (ctr_inc == i_len) done_d = 1'b1;
      end else if (&ctr_q) begin
        // Unbounded record already at all-ones: flag it, then hold or wrap.
        ovf_d = 1'b1;
        ctr_d = (SATURATE != 0) ? ctr_q : '0;
      end else begin
        ctr_d = ctr_inc;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      ctr_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ctr_q  <= ctr_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  assign o_ctr      = ctr_q;
  assign o_done     = done_q;
  assign o_done_nxt = done_d;
  assign o_overflow = ovf_q;

endmodule

// File: rtl/sample_mgmt_mc.sv
// Multi-channel sample record manager: IDLE/RECORD/DONE control around N_CH channel counters.
module sample_mgmt_mc
  import sample_mgmt_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int CTR_WIDTH = DEF_CTR_WIDTH,
  parameter int SATURATE  = DEF_SATURATE
) (
  input  logic                      i_clk,
  input  logic                      i_nrst,
  input  logic                      i_ce,
  input  logic                      i_new_record,
  input  logic [CTR_WIDTH-1:0]      i_record_len,
  input  logic [N_CH-1:0]           i_signal_valid,
  output logic [N_CH*CTR_WIDTH-1:0] o_ctr,
  output logic                      o_active,
  output logic [N_CH-1:0]           o_ch_done,
  output logic                      o_record_done,
  output logic [N_CH-1:0]           o_overflow
);

  state_e               state_q, state_d;
  logic [CTR_WIDTH-1:0] len_q, len_d;
  logic                 active_q, active_d;
  logic                 rdone_q, rdone_d;
  logic                 clr;
  logic                 cnt_en;
  logic [N_CH-1:0]      done_nxt;

  // A new record takes priority over counting, so same-cycle strobes are dropped.
  assign clr    = i_ce & i_new_record;
  assign cnt_en = i_ce & ~i_new_record & (state_q == RECORD);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rdone_d = 1'b0;
    if (clr) begin
      state_d = RECORD;
      len_d   = i_record_len;
    end else if (cnt_en && (|len_q) && (&done_nxt)) begin
      state_d = DONE;
      rdone_d = 1'b1;
    end
    active_d = (state_d == RECORD);
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      active_q <= 1'b0;
      rdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      active_q <= active_d;
      rdone_q  <= rdone_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    sample_ch_ctr #(
      .CTR_WIDTH (CTR_WIDTH),
      .SATURATE  (SATURATE)
    ) u_ch (
      .i_clk      (i_clk),
      .i_nrst     (i_nrst),
      .i_clr      (clr),
      .i_inc      (cnt_en & i_signal_valid[k]),
      .i_len      (len_q),
      .o_ctr      (o_ctr[k*CTR_WIDTH +: CTR_WIDTH]),
      .o_done     (o_ch_done[k]),
      .o_done_nxt (done_nxt[k]),
      .o_overflow (o_overflow[k])
    );
  end

  assign o_active      = active_q;
  assign o_record_done = rdone_q;

endmodule
